// File: rtl/vliw_regfile_mp.sv
// Multi-lane VLIW register file: N lanes x (2 async read + 1 sync write), x0 hardwired,
// optional write-to-read bypass, highest-lane-wins collisions and a busy scoreboard.
module vliw_regfile_mp #(
  parameter  int NUM_LANES = 4,
  parameter  int XLEN      = 32,
  parameter  int NREGS     = 32,
  parameter  int BYPASS    = 1,
  parameter  int CNT_W     = 16,
  localparam int AW        = $clog2(NREGS),
  localparam int NP        = NUM_LANES * 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NP*AW-1:0]         rd_addr,
  output logic [NP*XLEN-1:0]       rd_data,
  output logic [NP-1:0]            rd_busy,
  input  logic [NUM_LANES-1:0]     wr_en,
  input  logic [NUM_LANES*AW-1:0]  wr_addr,
  input  logic [NUM_LANES*XLEN-1:0] wr_data,
  input  logic [NUM_LANES-1:0]     rsv_en,
  input  logic [NUM_LANES*AW-1:0]  rsv_addr,
  output logic [NREGS-1:0]         busy_vec,
  output logic                     wr_conflict,
  output logic [CNT_W-1:0]         conflict_cnt
);

  logic [XLEN-1:0]      regs    [NREGS];
  logic [AW-1:0]        wa      [NUM_LANES];
  logic [XLEN-1:0]      wd      [NUM_LANES];
  logic [AW-1:0]        rsa     [NUM_LANES];
  logic [AW-1:0]        ra      [NP];
  logic [NUM_LANES-1:0] eff;
  logic [NUM_LANES-1:0] rsv_ok;

  logic [NREGS-1:0]     wr_hit;
  logic [NREGS-1:0]     rsv_hit;
  logic [XLEN-1:0]      wr_val  [NREGS];
  logic                 collide;

  // Writes and reservations to x0 or during reset never become effective.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      wa[l]     = wr_addr[l*AW +: AW];
      wd[l]     = wr_data[l*XLEN +: XLEN];
      rsa[l]    = rsv_addr[l*AW +: AW];
      eff[l]    = wr_en[l] && (wa[l] != '0) && !rst;
      rsv_ok[l] = rsv_en[l] && (rsa[l] != '0) && !rst;
    end
    for (int p = 0; p < NP; p++) begin
      ra[p] = rd_addr[p*AW +: AW];
    end
  end

  // Ascending lane scan: the last matching lane (highest index) owns the register.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    collide = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (eff[l] && (wa[l] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wd[l];
        end
        if (rsv_ok[l] && (rsa[l] == AW'(r))) begin
          rsv_hit[r] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (eff[i] && eff[j] && (wa[i] == wa[j])) begin
          collide = 1'b1;
        end
      end
    end
  end

  // Bypassed reads also mask rd_busy when the pending result lands this cycle.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NP; p++) begin
      if (!rst && (ra[p] != '0)) begin
        if ((BYPASS != 0) && wr_hit[ra[p]]) begin
          rd_data[p*XLEN +: XLEN] = wr_val[ra[p]];
        end else begin
          rd_data[p*XLEN +: XLEN] = regs[ra[p]];
        end
        rd_busy[p] = busy_vec[ra[p]] && !((BYPASS != 0) && wr_hit[ra[p]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy_vec     <= '0;
      wr_conflict  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
      // Reservation wins over a same-cycle completing write.
      busy_vec    <= rsv_hit | (busy_vec & ~wr_hit);
      wr_conflict <= collide;
      if (collide && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vliw_regfile_mp.sv
// Directed bench for vliw_regfile_mp: one bypassing and one non-bypassing instance
// share the same stimulus; expected values are hand-computed constants.
module tb_vliw_regfile_mp;
  localparam int NL = 4;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int NP = NL * 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*AW-1:0]  rd_addr;
  logic [NL-1:0]     wr_en;
  logic [NL*AW-1:0]  wr_addr;
  logic [NL*XL-1:0]  wr_data;
  logic [NL-1:0]     rsv_en;
  logic [NL*AW-1:0]  rsv_addr;

  logic [NP*XL-1:0]  rd_data_b,  rd_data_n;
  logic [NP-1:0]     rd_busy_b,  rd_busy_n;
  logic [NR-1:0]     busy_vec_b, busy_vec_n;
  logic              wr_conflict_b, wr_conflict_n;
  logic [CW-1:0]     conflict_cnt_b, conflict_cnt_n;

  int n_assert = 0;
  int n_fail   = 0;

  vliw_regfile_mp #(.NUM_LANES(NL), .XLEN(XL), .NREGS(NR), .BYPASS(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec_b), .wr_conflict(wr_conflict_b), .conflict_cnt(conflict_cnt_b));

  vliw_regfile_mp #(.NUM_LANES(NL), .XLEN(XL), .NREGS(NR), .BYPASS(0), .CNT_W(CW)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec_n), .wr_conflict(wr_conflict_n), .conflict_cnt(conflict_cnt_n));

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = '0;
    rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int l, input logic [AW-1:0] a, input logic [XL-1:0] d);
    wr_en[l]              = 1'b1;
    wr_addr[l*AW +: AW]   = a;
    wr_data[l*XL +: XL]   = d;
  endtask

  task automatic set_rsv(input int l, input logic [AW-1:0] a);
    rsv_en[l]             = 1'b1;
    rsv_addr[l*AW +: AW]  = a;
  endtask

  // checker
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XL-1:0] rdb(input int p);
    return rd_data_b[p*XL +: XL];
  endfunction

  function automatic logic [XL-1:0] rdn(input int p);
    return rd_data_n[p*XL +: XL];
  endfunction

  initial begin
    rst     = 1'b1;
    rd_addr = '0;
    idle();
    tick();
    tick();

    // reset state
    set_rd(0, 5'd5);
    settle();
    check("rst_rd_data", 64'(rdb(0)), 64'h0);
    check("rst_rd_busy", 64'(rd_busy_b), 64'h0);
    check("rst_busy_vec", 64'(busy_vec_b), 64'h0);
    check("rst_conflict", 64'(wr_conflict_b), 64'h0);
    check("rst_cnt", 64'(conflict_cnt_b), 64'h0);

    // 1: write r5, reserve r6, then reset mid-operation
    rst = 1'b0;
    set_wr(0, 5'd5, 32'hDEADBEEF);
    set_rsv(1, 5'd6);
    tick();
    idle();
    settle();
    check("r5_written_b", 64'(rdb(0)), 64'hDEADBEEF);
    check("r5_written_n", 64'(rdn(0)), 64'hDEADBEEF);
    check("r6_busy", 64'(busy_vec_b), 64'h40);
    rst = 1'b1;
    set_wr(0, 5'd5, 32'h55);
    set_rsv(2, 5'd7);
    settle();
    check("rd_during_rst", 64'(rdb(0)), 64'h0);
    tick();
    rst = 1'b0;
    idle();
    settle();
    check("r5_after_rst", 64'(rdb(0)), 64'h0);
    check("busy_after_rst", 64'(busy_vec_b), 64'h0);
    check("cnt_after_rst", 64'(conflict_cnt_b), 64'h0);

    // 2: x0 writes/reservations are dropped, no collision on addr 0
    set_rd(0, 5'd0);
    set_wr(1, 5'd0, 32'h1234);
    set_wr(2, 5'd0, 32'h99);
    set_rsv(1, 5'd0);
    settle();
    check("x0_bypass_rd", 64'(rdb(0)), 64'h0);
    tick();
    idle();
    settle();
    check("x0_rd", 64'(rdb(0)), 64'h0);
    check("x0_busy", 64'(busy_vec_b), 64'h0);
    check("x0_no_conflict", 64'(wr_conflict_b), 64'h0);
    check("x0_rd_busy", 64'(rd_busy_b[0]), 64'h0);

    // 3: three-lane collision on r7, highest lane wins
    set_rd(2, 5'd7);
    set_wr(0, 5'd7, 32'h11);
    set_wr(2, 5'd7, 32'h22);
    set_wr(3, 5'd7, 32'h33);
    settle();
    check("coll_bypass_b", 64'(rdb(2)), 64'h33);
    check("coll_bypass_n", 64'(rdn(2)), 64'h0);
    tick();
    idle();
    settle();
    check("coll_r7_b", 64'(rdb(2)), 64'h33);
    check("coll_r7_n", 64'(rdn(2)), 64'h33);
    check("coll_pulse", 64'(wr_conflict_b), 64'h1);
    check("coll_cnt1", 64'(conflict_cnt_b), 64'h1);
    // distinct-address multi-lane write: no collision
    set_wr(0, 5'd8, 32'h1);
    set_wr(1, 5'd10, 32'h2);
    tick();
    idle();
    settle();
    check("coll_pulse_end", 64'(wr_conflict_b), 64'h0);
    check("coll_cnt_hold", 64'(conflict_cnt_b), 64'h1);
    set_rd(3, 5'd10);
    settle();
    check("r10_written", 64'(rdb(3)), 64'h2);
    // saturation: 2^CW+3 colliding cycles on r11
    set_rd(1, 5'd11);
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      set_wr(0, 5'd11, 32'hF0);
      set_wr(1, 5'd11, 32'(i));
      tick();
      idle();
      settle();
      check("sat_cnt", 64'(conflict_cnt_b), 64'((i + 2 > 15) ? 15 : i + 2));
      check("sat_r11", 64'(rdb(1)), 64'(i));
    end
    check("sat_pulse", 64'(wr_conflict_b), 64'h1);
    tick();
    check("sat_pulse_end", 64'(wr_conflict_b), 64'h0);
    check("sat_hold", 64'(conflict_cnt_b), 64'hF);
    check("sat_hold_n", 64'(conflict_cnt_n), 64'hF);

    // 4: bypass vs. no-bypass on r3 read by lane2 rs1
    set_rd(4, 5'd3);
    set_wr(0, 5'd3, 32'hA5A5);
    settle();
    check("byp_same_b", 64'(rdb(4)), 64'hA5A5);
    check("byp_same_n", 64'(rdn(4)), 64'h0);
    tick();
    idle();
    settle();
    check("byp_next_n", 64'(rdn(4)), 64'hA5A5);

    // 5: scoreboard on r9
    set_rd(0, 5'd9);
    set_rsv(0, 5'd9);
    settle();
    check("sb_rsv_same", 64'(rd_busy_b[0]), 64'h0);
    tick();
    idle();
    settle();
    check("sb_busy_vec", 64'(busy_vec_b), 64'h200);
    check("sb_rd_busy_b", 64'(rd_busy_b[0]), 64'h1);
    check("sb_rd_busy_n", 64'(rd_busy_n[0]), 64'h1);
    tick();
    tick();
    check("sb_still_busy", 64'(busy_vec_b[9]), 64'h1);
    set_wr(0, 5'd9, 32'h77);
    settle();
    check("sb_clear_b", 64'(rd_busy_b[0]), 64'h0);
    check("sb_clear_n", 64'(rd_busy_n[0]), 64'h1);
    tick();
    idle();
    settle();
    check("sb_cleared_b", 64'(busy_vec_b), 64'h0);
    check("sb_cleared_n", 64'(busy_vec_n), 64'h0);
    check("sb_r9", 64'(rdb(0)), 64'h77);

    // 6: set/clear race on r4
    set_rd(0, 5'd4);
    set_rsv(0, 5'd4);
    tick();
    idle();
    settle();
    check("race_busy", 64'(busy_vec_b[4]), 64'h1);
    set_wr(1, 5'd4, 32'hCAFE);
    set_rsv(3, 5'd4);
    settle();
    check("race_rd_busy", 64'(rd_busy_b[0]), 64'h0);
    tick();
    idle();
    settle();
    check("race_keep_busy", 64'(busy_vec_b), 64'h10);
    check("race_r4", 64'(rdb(0)), 64'hCAFE);
    check("race_rd_busy2", 64'(rd_busy_b[0]), 64'h1);
    // reserving an already-busy register keeps it busy without counting
    set_rsv(2, 5'd4);
    tick();
    idle();
    settle();
    check("rerv_busy", 64'(busy_vec_b), 64'h10);
    check("rerv_no_cnt", 64'(wr_conflict_b), 64'h0);
    set_wr(2, 5'd4, 32'hBEEF);
    tick();
    idle();
    settle();
    check("race_final_busy", 64'(busy_vec_b), 64'h0);
    check("race_final_r4", 64'(rdn(0)), 64'hBEEF);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
